// File: rtl/cpu_ram_arb.sv
// rtl/cpu_ram_arb.sv - two-port round-robin arbiter and cycle sequencer for the 1Kx8 2114 work RAM
module cpu_ram_arb #(
    parameter int unsigned ACC_CYC = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CPU_REQ,
    input  logic       CPU_WR,
    input  logic [9:0] CPU_A,
    input  logic [7:0] CPU_DO,
    output logic [7:0] CPU_DI,
    output logic       CPU_ACK,
    output logic       CPU_WAIT_AL,
    input  logic       DMA_REQ,
    input  logic       DMA_WR,
    input  logic [9:0] DMA_A,
    input  logic [7:0] DMA_DO,
    output logic [7:0] DMA_DI,
    output logic       DMA_ACK,
    output logic       RAM_AL,
    output logic       MW_AL,
    output logic [9:0] A,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    input  logic [7:0] D_IN
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        RECOV
    } state_t;

    localparam logic [3:0] ACC_LOAD = 4'(ACC_CYC - 1);

    state_t     state;
    logic [3:0] acc_cnt;
    logic       lat_wr;
    logic       lat_dma;
    logic       last_dma;
    logic       grant_dma;

    // On a tie the port that was not served last wins, so neither side starves.
    always_comb begin
        grant_dma = DMA_REQ && (!CPU_REQ || !last_dma);
    end

    assign CPU_WAIT_AL = ~(CPU_REQ & ~CPU_ACK);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            acc_cnt  <= 4'd0;
            lat_wr   <= 1'b0;
            lat_dma  <= 1'b0;
            last_dma <= 1'b1;
            RAM_AL   <= 1'b1;
            MW_AL    <= 1'b1;
            A        <= 10'd0;
            D_OUT    <= 8'd0;
            D_OE     <= 1'b0;
            CPU_DI   <= 8'd0;
            DMA_DI   <= 8'd0;
            CPU_ACK  <= 1'b0;
            DMA_ACK  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CPU_REQ || DMA_REQ) begin
                        state    <= SETUP;
                        lat_dma  <= grant_dma;
                        last_dma <= grant_dma;
                        lat_wr   <= grant_dma ? DMA_WR : CPU_WR;
                        A        <= grant_dma ? DMA_A : CPU_A;
                        D_OUT    <= grant_dma ? DMA_DO : CPU_DO;
                        D_OE     <= grant_dma ? DMA_WR : CPU_WR;
                        RAM_AL   <= 1'b0;
                        MW_AL    <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    acc_cnt <= ACC_LOAD;
                    MW_AL   <= ~lat_wr;
                end
                ACCESS: begin
                    if (acc_cnt == 4'd0) begin
                        state <= HOLD;
                        MW_AL <= 1'b1;
                        if (lat_dma) begin
                            DMA_ACK <= 1'b1;
                        end else begin
                            CPU_ACK <= 1'b1;
                        end
                        // Read data is taken at the end of the last ACCESS cycle.
                        if (!lat_wr) begin
                            if (lat_dma) begin
                                DMA_DI <= D_IN;
                            end else begin
                                CPU_DI <= D_IN;
                            end
                        end
                    end else begin
                        acc_cnt <= acc_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    state   <= RECOV;
                    RAM_AL  <= 1'b1;
                    D_OE    <= 1'b0;
                    CPU_ACK <= 1'b0;
                    DMA_ACK <= 1'b0;
                end
                RECOV: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_ram_arb.sv
// tb/tb_cpu_ram_arb.sv - directed self-checking bench for cpu_ram_arb with a 2114 RAM model
module tb_cpu_ram_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_wr, dma_req, dma_wr;
    logic [9:0] cpu_a, dma_a;
    logic [7:0] cpu_do, dma_do;
    logic [7:0] d_in;

    logic [7:0] cpu_di, dma_di, d_out;
    logic       cpu_ack, dma_ack, cpu_wait_al, ram_al, mw_al, d_oe;
    logic [9:0] a;

    logic [7:0] cpu_di_1, dma_di_1, d_out_1;
    logic       cpu_ack_1, dma_ack_1, cpu_wait_al_1, ram_al_1, mw_al_1, d_oe_1;
    logic [9:0] a_1;

    logic [7:0] cpu_di_15, dma_di_15, d_out_15;
    logic       cpu_ack_15, dma_ack_15, cpu_wait_al_15, ram_al_15, mw_al_15, d_oe_15;
    logic [9:0] a_15;

    logic [7:0] mem [0:1023];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign d_in = mem[a];

    always @(posedge clk) begin
        if (!ram_al && !mw_al && d_oe) mem[a] <= d_out;
    end

    cpu_ram_arb #(.ACC_CYC(2)) dut (
        .CLK(clk), .RST(rst),
        .CPU_REQ(cpu_req), .CPU_WR(cpu_wr), .CPU_A(cpu_a), .CPU_DO(cpu_do),
        .CPU_DI(cpu_di), .CPU_ACK(cpu_ack), .CPU_WAIT_AL(cpu_wait_al),
        .DMA_REQ(dma_req), .DMA_WR(dma_wr), .DMA_A(dma_a), .DMA_DO(dma_do),
        .DMA_DI(dma_di), .DMA_ACK(dma_ack),
        .RAM_AL(ram_al), .MW_AL(mw_al), .A(a), .D_OUT(d_out), .D_OE(d_oe), .D_IN(d_in)
    );

    cpu_ram_arb #(.ACC_CYC(1)) dut_1 (
        .CLK(clk), .RST(rst),
        .CPU_REQ(cpu_req), .CPU_WR(cpu_wr), .CPU_A(cpu_a), .CPU_DO(cpu_do),
        .CPU_DI(cpu_di_1), .CPU_ACK(cpu_ack_1), .CPU_WAIT_AL(cpu_wait_al_1),
        .DMA_REQ(dma_req), .DMA_WR(dma_wr), .DMA_A(dma_a), .DMA_DO(dma_do),
        .DMA_DI(dma_di_1), .DMA_ACK(dma_ack_1),
        .RAM_AL(ram_al_1), .MW_AL(mw_al_1), .A(a_1), .D_OUT(d_out_1), .D_OE(d_oe_1), .D_IN(d_in)
    );

    cpu_ram_arb #(.ACC_CYC(15)) dut_15 (
        .CLK(clk), .RST(rst),
        .CPU_REQ(cpu_req), .CPU_WR(cpu_wr), .CPU_A(cpu_a), .CPU_DO(cpu_do),
        .CPU_DI(cpu_di_15), .CPU_ACK(cpu_ack_15), .CPU_WAIT_AL(cpu_wait_al_15),
        .DMA_REQ(dma_req), .DMA_WR(dma_wr), .DMA_A(dma_a), .DMA_DO(dma_do),
        .DMA_DI(dma_di_15), .DMA_ACK(dma_ack_15),
        .RAM_AL(ram_al_15), .MW_AL(mw_al_15), .A(a_15), .D_OUT(d_out_15), .D_OE(d_oe_15), .D_IN(d_in)
    );

    task automatic do_reset();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One access on the ACC_CYC=2 instance; latency k counts negedges, the sampling edge being 1.
    task automatic access(input bit use_dma, input bit wr, input logic [9:0] addr,
                          input logic [7:0] data, output int lat, output int mw_low,
                          output bit stable, output bit wait_ok, output bit seen,
                          output logic [7:0] di);
        bit ack;
        lat = 0; mw_low = 0; stable = 1; wait_ok = 1; seen = 0; di = 8'h00;
        if (use_dma) begin
            dma_wr = wr; dma_a = addr; dma_do = data; dma_req = 1'b1;
        end else begin
            cpu_wr = wr; cpu_a = addr; cpu_do = data; cpu_req = 1'b1;
        end
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 2) begin
                cpu_a = ~addr; cpu_do = ~data; dma_a = ~addr; dma_do = ~data;
            end
            if (mw_al == 1'b0) mw_low++;
            if (!ram_al && (a !== addr)) stable = 0;
            if (!ram_al && wr && (d_out !== data || d_oe !== 1'b1)) stable = 0;
            if (!wr && d_oe !== 1'b0) stable = 0;
            ack = use_dma ? dma_ack : cpu_ack;
            if (!use_dma && (ack ? (cpu_wait_al !== 1'b1) : (cpu_wait_al !== 1'b0))) wait_ok = 0;
            if (ack) begin
                seen = 1;
                lat = k;
                di = use_dma ? dma_di : cpu_di;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bit seen;
        cpu_wr = 1'b1; cpu_a = 10'h200; cpu_do = 8'h42; cpu_req = 1'b1;
        dma_req = 1'b0; dma_wr = 1'b0; dma_a = 10'h000; dma_do = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ram_al, mw_al, d_oe, cpu_ack, dma_ack, cpu_wait_al} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=110000",
                     {ram_al, mw_al, d_oe, cpu_ack, dma_ack, cpu_wait_al});
        end
        checks++;
        if ({a, d_out, cpu_di, dma_di} !== 34'd0) begin
            errors++;
            $display("FAIL reset_data a=%h d_out=%h cpu_di=%h dma_di=%h want all 0", a, d_out, cpu_di, dma_di);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_al !== 1'b0 || a !== 10'h200) begin
            errors++;
            $display("FAIL reset_first_grant ram_al=%b a=%h want 0/200", ram_al, a);
        end
        seen = 0;
        for (int k = 2; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (cpu_ack) seen = 1;
        end
        cpu_req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_first_ack got=none want=ack");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat, mw; bit st, wt, seen; logic [7:0] di;
        do_reset();
        access(0, 1, 10'h3A5, 8'h5C, lat, mw, st, wt, seen, di);
        checks++;
        if (!seen || lat != 4) begin
            errors++;
            $display("FAIL wr_ack_latency got=%0d want=4", lat);
        end
        checks++;
        if (mw != 2) begin
            errors++;
            $display("FAIL wr_mw_width got=%0d want=2", mw);
        end
        checks++;
        if (!st || !wt) begin
            errors++;
            $display("FAIL wr_bus_stable stable=%0d wait=%0d want 1/1", st, wt);
        end
        checks++;
        if (mem[10'h3A5] !== 8'h5C) begin
            errors++;
            $display("FAIL wr_ram_content got=%h want=5c", mem[10'h3A5]);
        end
        access(0, 0, 10'h3A5, 8'h00, lat, mw, st, wt, seen, di);
        checks++;
        if (!seen || lat != 4 || mw != 0) begin
            errors++;
            $display("FAIL rd_timing lat=%0d mw=%0d want 4/0", lat, mw);
        end
        checks++;
        if (di !== 8'h5C || cpu_di !== 8'h5C) begin
            errors++;
            $display("FAIL rd_data at_ack=%h held=%h want=5c", di, cpu_di);
        end
        checks++;
        if (!st || !wt) begin
            errors++;
            $display("FAIL rd_bus_wait stable=%0d wait=%0d want 1/1", st, wt);
        end
    endtask

    task automatic test_isolation();
        int lat, mw; bit st, wt, seen; logic [7:0] di;
        do_reset();
        access(1, 0, 10'h3A5, 8'h00, lat, mw, st, wt, seen, di);
        checks++;
        if (!seen || dma_di !== 8'h5C || cpu_di !== 8'h00) begin
            errors++;
            $display("FAIL iso_dma_read dma_di=%h cpu_di=%h want 5c/00", dma_di, cpu_di);
        end
        access(1, 1, 10'h000, 8'hFF, lat, mw, st, wt, seen, di);
        access(0, 0, 10'h000, 8'h00, lat, mw, st, wt, seen, di);
        checks++;
        if (!seen || cpu_di !== 8'hFF || dma_di !== 8'h5C) begin
            errors++;
            $display("FAIL iso_cpu_read cpu_di=%h dma_di=%h want ff/5c", cpu_di, dma_di);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL iso_addr_latched stable=%0d want=1", st);
        end
    endtask

    task automatic test_contention();
        int n, rc, rd, hi_cnt;
        bit order [4];
        int at [4];
        bit overlap;
        n = 0; rc = 0; rd = 0; hi_cnt = 0; overlap = 0;
        for (int i = 0; i < 4; i++) begin order[i] = 0; at[i] = 0; end
        cpu_wr = 1'b1; cpu_a = 10'h010; cpu_do = 8'hC1;
        dma_wr = 1'b1; dma_a = 10'h020; dma_do = 8'hD1;
        cpu_req = 1'b1; dma_req = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 60 && n < 4; k++) begin
            @(negedge clk);
            if (n >= 1 && ram_al) hi_cnt++;
            if (cpu_ack && dma_ack) overlap = 1;
            if (cpu_ack) begin
                if (n < 4) begin order[n] = 0; at[n] = k; n++; end
                cpu_req = 1'b0; rc = 2;
            end else if (rc > 0) begin
                rc--;
                if (rc == 0) cpu_req = 1'b1;
            end
            if (dma_ack) begin
                if (n < 4) begin order[n] = 1; at[n] = k; n++; end
                dma_req = 1'b0; rd = 2;
            end else if (rd > 0) begin
                rd--;
                if (rd == 0) dma_req = 1'b1;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (n != 4 || {order[0], order[1], order[2], order[3]} !== 4'b0101) begin
            errors++;
            $display("FAIL cont_order n=%0d got=%b%b%b%b want=0101", n, order[0], order[1], order[2], order[3]);
        end
        checks++;
        if (at[0] != 4 || at[1] != 10 || at[2] != 16 || at[3] != 22) begin
            errors++;
            $display("FAIL cont_ack_times got=%0d,%0d,%0d,%0d want=4,10,16,22", at[0], at[1], at[2], at[3]);
        end
        checks++;
        if (overlap || hi_cnt != 6) begin
            errors++;
            $display("FAIL cont_ram_al_gaps overlap=%0d high_cycles=%0d want 0/6", overlap, hi_cnt);
        end
        checks++;
        if (mem[10'h010] !== 8'hC1 || mem[10'h020] !== 8'hD1) begin
            errors++;
            $display("FAIL cont_ram_content got=%h,%h want=c1,d1", mem[10'h010], mem[10'h020]);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, mw, acks; bit st, wt, seen; logic [7:0] di;
        do_reset();
        cpu_wr = 1'b1; cpu_a = 10'h155; cpu_do = 8'hAA; cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_al, mw_al, d_oe, cpu_ack} !== 4'b1100) begin
            errors++;
            $display("FAIL midrst_outputs got=%b want=1100", {ram_al, mw_al, d_oe, cpu_ack});
        end
        cpu_req = 1'b0;
        rst = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL midrst_no_ack got=%0d want=0", acks);
        end
        access(0, 1, 10'h155, 8'h66, lat, mw, st, wt, seen, di);
        checks++;
        if (!seen || lat != 4 || mw != 2) begin
            errors++;
            $display("FAIL midrst_recover lat=%0d mw=%0d want 4/2", lat, mw);
        end
        access(0, 0, 10'h155, 8'h00, lat, mw, st, wt, seen, di);
        checks++;
        if (cpu_di !== 8'h66) begin
            errors++;
            $display("FAIL midrst_readback got=%h want=66", cpu_di);
        end
    endtask

    task automatic test_acc_cyc();
        int lat1, lat2, lat15, mw1, mw2, mw15;
        lat1 = 0; lat2 = 0; lat15 = 0; mw1 = 0; mw2 = 0; mw15 = 0;
        do_reset();
        cpu_wr = 1'b1; cpu_a = 10'h0F0; cpu_do = 8'h3C; cpu_req = 1'b1;
        for (int k = 1; k <= 40 && lat15 == 0; k++) begin
            @(negedge clk);
            if (lat1 == 0) begin
                if (!mw_al_1) mw1++;
                if (cpu_ack_1) lat1 = k;
            end
            if (lat2 == 0) begin
                if (!mw_al) mw2++;
                if (cpu_ack) lat2 = k;
            end
            if (lat15 == 0) begin
                if (!mw_al_15) mw15++;
                if (cpu_ack_15) lat15 = k;
            end
        end
        cpu_req = 1'b0;
        checks++;
        if (lat1 != 3 || mw1 != 1) begin
            errors++;
            $display("FAIL acc1 lat=%0d mw=%0d want 3/1", lat1, mw1);
        end
        checks++;
        if (lat2 != 4 || mw2 != 2) begin
            errors++;
            $display("FAIL acc2 lat=%0d mw=%0d want 4/2", lat2, mw2);
        end
        checks++;
        if (lat15 != 17 || mw15 != 15) begin
            errors++;
            $display("FAIL acc15 lat=%0d mw=%0d want 17/15", lat15, mw15);
        end
        repeat (3) @(negedge clk);
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_a = 10'h000; cpu_do = 8'h00;
        dma_req = 1'b0; dma_wr = 1'b0; dma_a = 10'h000; dma_do = 8'h00;
        test_reset();
        test_write_read();
        test_isolation();
        test_contention();
        test_reset_mid_write();
        test_acc_cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_ram_arb.md
# cpu_ram_arb

Two-port arbiter and cycle sequencer for the CPU board 1K×8 work RAM (IC5/IC6 2114 pair). It shares the RAM between the Z80 bus (CPU port) and a secondary DMA/debug-loader port (DMA port). It generates the RAM_AL chip select, the MW_AL write strobe, the address mux and the data-bus direction control. The CPU is stalled through CPU_WAIT_AL while its access is pending; the tristate data bus is resolved at board top level from D_OUT/D_OE.

## Interface
Parameters:
- ACC_CYC, 2, cycles in ACCESS state (1–15); sets the MW_AL low width and the read access time.

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  synchronous reset, active-high
- CPU_REQ  in  1  CPU access request (decoded MREQ and RAM range); level, held until CPU_ACK
- CPU_WR  in  1  1 = write, 0 = read; stable while CPU_REQ is high
- CPU_A  in  10  CPU address
- CPU_DO  in  8  CPU write data
- CPU_DI  out  8  read data; valid while CPU_ACK is high, held until the next CPU read completes
- CPU_ACK  out  1  one-cycle completion pulse
- CPU_WAIT_AL  out  1  low while CPU_REQ=1 and CPU_ACK=0 (combinational)
- DMA_REQ, DMA_WR, DMA_A[9:0], DMA_DO[7:0]  in  same semantics as the CPU port
- DMA_DI  out  8  same semantics as CPU_DI
- DMA_ACK  out  1  same semantics as CPU_ACK
- RAM_AL  out  1  2114 CS, active low
- MW_AL  out  1  2114 WE, active low
- A  out  10  RAM address
- D_OUT  out  8  write data to RAM bus
- D_OE  out  1  1 = drive D_OUT onto the RAM bus
- D_IN  in  8  RAM bus read-back

## Operation
- States: IDLE, SETUP, ACCESS, HOLD, RECOV.
- IDLE: RAM deselected. If any REQ is high, grant one port, latch its A/WR/DO into internal registers, and go to SETUP.
- Arbitration: a single requester is granted directly. With both requesting, grant the port that was not granted last (round-robin). After reset, the last-grant pointer = DMA, so the CPU wins the first tie.
- SETUP (1 cycle): RAM_AL=0, MW_AL=1, A = latched address. For a write, D_OE=1 and D_OUT = latched data.
- ACCESS (ACC_CYC cycles, counter loads ACC_CYC-1 and counts down): RAM_AL=0. A write drives MW_AL=0 and D_OE=1. A read keeps MW_AL=1, D_OE=0, and captures D_IN into the granted port's DI register on the final ACCESS edge.
- HOLD (1 cycle): RAM_AL=0, MW_AL=1, address held, D_OE held for writes (data hold after WE rise). The granted port's ACK=1.
- RECOV (1 cycle): RAM_AL=1, D_OE=0, no arbitration. The requester drops REQ here. Next state is IDLE.
- A, D_OUT and the DI registers are driven only from latched values, so port inputs may change after the grant without effect.
- CPU_DI and DMA_DI are separate registers; a read on one port never disturbs the other port's DI.
- The non-granted port's REQ stays pending and is considered at the next IDLE. Neither port can starve: after one access, a waiting requester wins the next tie.

## Timing
- Reset values: RAM_AL=1, MW_AL=1, D_OE=0, A=0, D_OUT=0, CPU_DI=0, DMA_DI=0, CPU_ACK=0, DMA_ACK=0, state=IDLE, pointer=DMA.
- Access length = ACC_CYC+4 cycles per grant (IDLE, SETUP, ACCESS×ACC_CYC, HOLD, RECOV). ACK rises ACC_CYC+2 cycles after the edge that samples REQ in IDLE.
- Peak throughput is one access per ACC_CYC+4 cycles (6 at default).
- Write: MW_AL low for exactly ACC_CYC cycles. A, D_OUT and D_OE are stable from SETUP through HOLD, giving 1 cycle of setup and 1 cycle of hold around MW_AL.
- Read data is sampled at the end of the last ACCESS cycle and is visible on xx_DI from HOLD onward.
- Requester contract: REQ must be low at the edge ending RECOV. If REQ is still high in IDLE, it is a new access.
- RST mid-access: at the next edge all outputs take their reset values, no ACK is issued, and the pending access is abandoned. A write may be partially applied to RAM, which is acceptable.
- RST has priority over all state transitions.

## Test plan
- Reset: assert RST for 2 cycles with CPU_REQ=1 -> RAM_AL=1, MW_AL=1, D_OE=0, ACKs=0, CPU_WAIT_AL=0. After release, the CPU grant occurs on the first IDLE edge.
- CPU write then read, ACC_CYC=2: write 0x3A5 <= 0x5C -> MW_AL low for exactly 2 cycles with A=0x3A5 and D_OUT=0x5C from SETUP through HOLD; CPU_ACK pulses 4 cycles after the grant edge. A read of 0x3A5 then returns CPU_DI=0x5C during ACK; CPU_WAIT_AL releases in the ACK cycle.
- Contention: CPU_REQ and DMA_REQ rise together from reset, both issuing writes -> grant order CPU, DMA, CPU, DMA with back-to-back 6-cycle accesses and no overlapping RAM_AL windows.
- Isolation: DMA writes 0x000 <= 0xFF, CPU reads 0x000 -> CPU_DI=0xFF and DMA_DI unchanged. Changing CPU_A during ACCESS does not change A.
- Reset mid-write: RST asserted in the first ACCESS cycle -> MW_AL=1 and RAM_AL=1 at the next edge, no ACK, and a new request after release completes normally.
- ACC_CYC=1 and ACC_CYC=15: MW_AL low width equals ACC_CYC, and the ACK latency equals ACC_CYC+2 cycles after the grant edge.
